// File: rtl/l2_pmem_line_adaptor.sv
// L2 physical-memory side adaptor: turns 256-bit line reads/writes into
// 4-beat 64-bit bursts, assembling read beats and serializing write lines.
module l2_pmem_line_adaptor #(
  parameter int unsigned s_line    = 256,
  parameter int unsigned s_burst   = 64,
  parameter int unsigned num_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned cw = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam int unsigned bw = $clog2(s_burst);
  localparam logic [cw-1:0] last_beat = cw'(num_beats - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state;
  logic [cw-1:0]       cnt;
  logic [s_line-1:0]   buffer;
  logic [s_line-1:0]   rd_line;
  logic [cw+bw-1:0]    beat_base;

  assign beat_base = {cnt, {bw{1'b0}}};
  assign burst_o   = buffer[beat_base +: s_burst];

  // Buffer with the current read beat merged in, so line_o can be loaded
  // with the complete line on the same edge that captures the last beat.
  always_comb begin
    rd_line = buffer;
    rd_line[beat_base +: s_burst] = burst_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      buffer    <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          if (read_i) begin
            address_o <= {address_i[31:5], 5'b0};
            read_o    <= 1'b1;
            state     <= RD;
          end else if (write_i) begin
            address_o <= {address_i[31:5], 5'b0};
            buffer    <= line_i;
            write_o   <= 1'b1;
            state     <= WR;
          end
        end
        RD: begin
          if (resp_i) begin
            buffer <= rd_line;
            cnt    <= cnt + 1'b1;
            if (cnt == last_beat) begin
              line_o <= rd_line;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == last_beat) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
